// File: rtl/amoa_param_mc_if.sv
// Operand/result bus for the approximate multi-operand adder.
// master = operand source / result sink, slave = the adder block.
interface amoa_param_mc_if #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = W + $clog2(N)
);
    logic [N*W-1:0] x;
    logic           in_valid;
    logic [SW-1:0]  summ;
    logic           out_valid;
    logic           stall;

    modport master (
        output x, in_valid,
        input  summ, out_valid, stall
    );

    modport slave (
        input  x, in_valid,
        output summ, out_valid, stall
    );
endinterface

// File: rtl/amoa_param_mc.sv
// Multi-cycle approximate multi-operand adder.
// Latches N operands, then sums K of them per cycle over R = ceil(N/K) rounds.
// The low APX bits of each operand are dropped before summing.
// Build option AMOA_APX_COMP_EN: add the mean truncation error once in the
// final round; without it the result is pure truncation.

// One adder lane: picks operand (idx*K + LANE), masks its low bits, zero
// contributes when the index runs past N (partial last group).
module amoa_lane #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SW   = 11,
    parameter int K    = 2,
    parameter int APX  = 2,
    parameter int IW   = 2,
    parameter int LANE = 0
) (
    input  logic [N-1:0][W-1:0] ops,
    input  logic [IW-1:0]       idx,
    output logic [SW-1:0]       val
);
    localparam logic [W-1:0] LOW  = W'((1 << APX) - 1);
    localparam logic [W-1:0] MASK = ~LOW;

    int sel;

    // Operand select as a compare-mux so out-of-range indices fall to zero.
    always_comb begin
        sel = int'(idx) * K + LANE;
        val = '0;
        for (int j = 0; j < N; j++) begin
            if (j == sel) val = SW'(ops[j] & MASK);
        end
    end
endmodule

module amoa_param_mc #(
    parameter int N   = 8,
    parameter int W   = 8,
    parameter int K   = 2,
    parameter int APX = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    amoa_param_mc_if.slave       bus
);
    localparam int SW = W + $clog2(N);
    localparam int R  = (N + K - 1) / K;
    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam logic [IW-1:0] LAST = IW'(R - 1);

`ifdef AMOA_APX_COMP_EN
    localparam logic [SW-1:0] COMP = SW'((N * ((1 << APX) - 1)) >> 1);
`else
    localparam logic [SW-1:0] COMP = '0;
`endif

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state;
    logic [N-1:0][W-1:0]  op_q;
    logic [SW-1:0]        acc;
    logic [IW-1:0]        idx;
    logic [SW-1:0]        summ_q;
    logic                 out_valid_q;
    logic                 stall_q;
    logic [K-1:0][SW-1:0] lane_val;
    logic [SW-1:0]        group_sum;

    // K lanes feeding one group sum per round.
    for (genvar l = 0; l < K; l++) begin : g_lane
        amoa_lane #(
            .N(N), .W(W), .SW(SW), .K(K), .APX(APX), .IW(IW), .LANE(l)
        ) u_lane (
            .ops (op_q),
            .idx (idx),
            .val (lane_val[l])
        );
    end

    // Reduce the lane outputs of the current round; widths cannot overflow.
    always_comb begin
        group_sum = '0;
        for (int l = 0; l < K; l++) group_sum = group_sum + lane_val[l];
    end

    // Control FSM with registered status; out_valid is a one-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            acc         <= '0;
            idx         <= '0;
            summ_q      <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q    <= bus.x;
                        acc     <= '0;
                        idx     <= '0;
                        state   <= BUSY;
                        stall_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (idx == LAST) begin
                        summ_q      <= acc + group_sum + COMP;
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                        stall_q     <= 1'b0;
                    end else begin
                        acc <= acc + group_sum;
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.summ      = summ_q;
    assign bus.out_valid = out_valid_q;
    assign bus.stall     = stall_q;
endmodule
